// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - opcodes, state encoding and ALU operand addresses shared by sys_ctrl
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int ALU_OPA_ADDR = 0;
  localparam int ALU_OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    ALU_A,
    ALU_B,
    ALU_FUNC,
    ALU_WAIT,
    TX_SEND
  } sys_ctrl_state_e;

endpackage

// File: rtl/sys_ctrl_if.sv
// rtl/sys_ctrl_if.sv - RX, register-file, ALU and TX signals around the sys_ctrl sequencer
interface sys_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUNC_WIDTH = 4
);
  logic                    rx_valid_in;
  logic [DATA_WIDTH-1:0]   rx_data_in;
  logic                    rf_wr_en;
  logic                    rf_rd_en;
  logic [ADDR_WIDTH-1:0]   rf_addr;
  logic [DATA_WIDTH-1:0]   rf_wr_data;
  logic [DATA_WIDTH-1:0]   rf_rd_data;
  logic                    rf_rd_valid;
  logic                    alu_en;
  logic [FUNC_WIDTH-1:0]   alu_func;
  logic [2*DATA_WIDTH-1:0] alu_out;
  logic                    alu_out_valid;
  logic [DATA_WIDTH-1:0]   tx_data_out;
  logic                    tx_valid_out;
  logic                    tx_ready_in;
  logic                    frame_err_out;

  modport master (
    input  rx_valid_in, rx_data_in, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_ready_in,
    output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_func, tx_data_out, tx_valid_out,
           frame_err_out
  );

  modport slave (
    output rx_valid_in, rx_data_in, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_ready_in,
    input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_func, tx_data_out, tx_valid_out,
           frame_err_out
  );
endinterface

// File: rtl/sys_ctrl_tx_buf.sv
// rtl/sys_ctrl_tx_buf.sv - 2-entry byte buffer feeding the TX handshake, low byte first
module sys_ctrl_tx_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load1,
  input  logic                    load2,
  input  logic [2*DATA_WIDTH-1:0] load_data,
  input  logic                    tx_ready,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  output logic                    empty,
  output logic                    last
);
  logic [DATA_WIDTH-1:0] hi_q;
  logic [1:0]            count;

  assign empty = (count == 2'd0);
  assign last  = (count == 2'd1);

  // tx_data is the head register itself, so it only moves on a pop or a load
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= 2'd0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      hi_q     <= '0;
    end else if (load2) begin
      tx_data  <= load_data[DATA_WIDTH-1:0];
      hi_q     <= load_data[2*DATA_WIDTH-1:DATA_WIDTH];
      count    <= 2'd2;
      tx_valid <= 1'b1;
    end else if (load1) begin
      tx_data  <= load_data[DATA_WIDTH-1:0];
      count    <= 2'd1;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      tx_data  <= hi_q;
      count    <= count - 2'd1;
      tx_valid <= (count == 2'd2);
    end
  end
endmodule

// File: rtl/sys_ctrl.sv
// rtl/sys_ctrl.sv - command sequencer: frame decode, RF/ALU strobes, TX return (optional SYS_CTRL_TIMEOUT_EN)
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUNC_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic        clk,
  input logic        reset,
  sys_ctrl_if.master bus
);
  sys_ctrl_state_e         state;
  logic                    rx_valid;
  logic [DATA_WIDTH-1:0]   rx_byte;
  logic                    buf_load1;
  logic                    buf_load2;
  logic [2*DATA_WIDTH-1:0] buf_din;
  logic                    buf_empty;
  logic                    buf_last;
  logic                    tx_done;
  logic                    timeout;

  assign rx_valid  = bus.rx_valid_in;
  assign rx_byte   = bus.rx_data_in;
  assign buf_load1 = (state == RD_WAIT) && bus.rf_rd_valid;
  assign buf_load2 = (state == ALU_WAIT) && bus.alu_out_valid;
  assign buf_din   = buf_load2 ? bus.alu_out : {{DATA_WIDTH{1'b0}}, bus.rf_rd_data};
  assign tx_done   = (state == TX_SEND) &&
                     (buf_empty || (bus.tx_valid_out && bus.tx_ready_in && buf_last));

  sys_ctrl_tx_buf #(.DATA_WIDTH(DATA_WIDTH)) u_tx_buf (
    .clk       (clk),
    .reset     (reset),
    .load1     (buf_load1),
    .load2     (buf_load2),
    .load_data (buf_din),
    .tx_ready  (bus.tx_ready_in),
    .tx_data   (bus.tx_data_out),
    .tx_valid  (bus.tx_valid_out),
    .empty     (buf_empty),
    .last      (buf_last)
  );

`ifdef SYS_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_cnt;

  // every state change is caused by one of the clear terms, so no next-state copy is needed
  assign timeout = (state inside {WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUNC}) &&
                   (idle_cnt == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset || rx_valid || buf_load1 || buf_load2 || tx_done || timeout) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TO_W'(TIMEOUT_CYCLES)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) bus.frame_err_out <= 1'b0;
    else       bus.frame_err_out <= timeout;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
  assign bus.frame_err_out  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      bus.rf_wr_en   <= 1'b0;
      bus.rf_rd_en   <= 1'b0;
      bus.rf_addr    <= '0;
      bus.rf_wr_data <= '0;
      bus.alu_en     <= 1'b0;
      bus.alu_func   <= '0;
    end else begin
      bus.rf_wr_en <= 1'b0;
      bus.rf_rd_en <= 1'b0;
      bus.alu_en   <= 1'b0;
      if (timeout) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (rx_valid) begin
            case (rx_byte)
              DATA_WIDTH'(CMD_RF_WR):   state <= WR_ADDR;
              DATA_WIDTH'(CMD_RF_RD):   state <= RD_ADDR;
              DATA_WIDTH'(CMD_ALU_OP):  state <= ALU_A;
              DATA_WIDTH'(CMD_ALU_NOP): state <= ALU_FUNC;
              default:                  state <= IDLE;
            endcase
          end
          WR_ADDR: if (rx_valid) begin
            bus.rf_addr <= rx_byte[ADDR_WIDTH-1:0];
            state       <= WR_DATA;
          end
          WR_DATA: if (rx_valid) begin
            bus.rf_wr_data <= rx_byte;
            bus.rf_wr_en   <= 1'b1;
            state          <= IDLE;
          end
          RD_ADDR: if (rx_valid) begin
            bus.rf_addr  <= rx_byte[ADDR_WIDTH-1:0];
            bus.rf_rd_en <= 1'b1;
            state        <= RD_WAIT;
          end
          RD_WAIT:  if (buf_load1) state <= TX_SEND;
          ALU_A: if (rx_valid) begin
            bus.rf_addr    <= ADDR_WIDTH'(ALU_OPA_ADDR);
            bus.rf_wr_data <= rx_byte;
            bus.rf_wr_en   <= 1'b1;
            state          <= ALU_B;
          end
          ALU_B: if (rx_valid) begin
            bus.rf_addr    <= ADDR_WIDTH'(ALU_OPB_ADDR);
            bus.rf_wr_data <= rx_byte;
            bus.rf_wr_en   <= 1'b1;
            state          <= ALU_FUNC;
          end
          ALU_FUNC: if (rx_valid) begin
            bus.alu_func <= rx_byte[FUNC_WIDTH-1:0];
            bus.alu_en   <= 1'b1;
            state        <= ALU_WAIT;
          end
          ALU_WAIT: if (buf_load2) state <= TX_SEND;
          TX_SEND:  if (tx_done) state <= IDLE;
          default:  state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sys_ctrl.sv
// tb/tb_sys_ctrl.sv - self-checking bench for sys_ctrl against a frame-level command model
module tb_sys_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FW = 4;
  localparam int K_WR = 1;
  localparam int K_RD = 2;
  localparam int K_ALU = 3;

  typedef struct {
    int kind;
    int addr;
    int data;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  ev_t exp_q[$];
  int  tx_q[$];
  int  frame[$];
  int  wait_kind = 0;
  int  tx_hist[$];
  int  wr_count = 0, rd_count = 0, alu_count = 0, tx_count = 0;
  int  err_pulses = 0, err_cyc = 0, byte_cyc = 0;
  int  last_wr_addr = -1, last_wr_data = -1, last_rd_addr = -1, last_func = -1;
  int  held_data = 0;
  bit  hold_pending = 1'b0;
  int  base, aa_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sys_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUNC_WIDTH(FW)) bus ();

  sys_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUNC_WIDTH(FW), .TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int out_vec();
    return int'({bus.rf_wr_en, bus.rf_rd_en, bus.rf_addr, bus.rf_wr_data, bus.alu_en,
                 bus.alu_func, bus.tx_valid_out, bus.tx_data_out, bus.frame_err_out});
  endfunction

  function automatic void push_ev(input int kind, input int addr, input int data, input int c);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  // Frame model: collect bytes after an opcode, emit the strobe a frame implies one cycle later
  function automatic void model_byte(input int b, input int k);
    if (wait_kind != 0) return;
    if (frame.size() == 0) begin
      if (b == 'hAA || b == 'hBB || b == 'hCC || b == 'hDD) frame.push_back(b);
      return;
    end
    frame.push_back(b);
    case (frame[0])
      'hAA: if (frame.size() == 3) begin
        push_ev(K_WR, frame[1] % 16, frame[2], k + 1); frame.delete();
      end
      'hBB: begin
        push_ev(K_RD, b % 16, 0, k + 1); frame.delete(); wait_kind = 1;
      end
      'hCC: begin
        if (frame.size() == 2) push_ev(K_WR, 0, b, k + 1);
        else if (frame.size() == 3) push_ev(K_WR, 1, b, k + 1);
        else begin
          push_ev(K_ALU, 0, b % 16, k + 1); frame.delete(); wait_kind = 2;
        end
      end
      default: begin
        push_ev(K_ALU, 0, b % 16, k + 1); frame.delete(); wait_kind = 2;
      end
    endcase
  endfunction

  task automatic send_byte(input int b);
    @(posedge clk); #1;
    bus.rx_valid_in = 1'b1;
    bus.rx_data_in  = DW'(b);
    byte_cyc = cyc;
    model_byte(b, cyc);
    @(posedge clk); #1;
    bus.rx_valid_in = 1'b0;
  endtask

  task automatic respond_rd(input int d, input bit with_byte, input int b);
    @(posedge clk); #1;
    bus.rf_rd_valid = 1'b1;
    bus.rf_rd_data  = DW'(d);
    if (with_byte) begin
      bus.rx_valid_in = 1'b1;
      bus.rx_data_in  = DW'(b);
      model_byte(b, cyc);
    end
    if (wait_kind == 1) begin
      tx_q.push_back(d); wait_kind = 3;
    end
    @(posedge clk); #1;
    bus.rf_rd_valid = 1'b0;
    bus.rx_valid_in = 1'b0;
  endtask

  task automatic respond_alu(input int v);
    @(posedge clk); #1;
    bus.alu_out_valid = 1'b1;
    bus.alu_out       = 16'(v);
    if (wait_kind == 2) begin
      tx_q.push_back(v % 256); tx_q.push_back(v / 256); wait_kind = 3;
    end
    @(posedge clk); #1;
    bus.alu_out_valid = 1'b0;
  endtask

  task automatic wait_tx_done(input int limit);
    for (int i = 0; i < limit && wait_kind != 0; i++) @(posedge clk);
    check("tx_done_within_budget", wait_kind, 0);
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    reset = 1'b1;
    frame.delete(); tx_q.delete(); exp_q.delete(); wait_kind = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("outputs_zero_in_reset", out_vec(), 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic match_ev(input string name, input int kind, input int addr, input int data);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s_unexpected: got strobe at cycle %0d, required none", name, cyc);
    end else begin
      e = exp_q.pop_front();
      check({name, "_kind"}, kind, e.kind);
      check({name, "_addr"}, addr, e.addr);
      check({name, "_data"}, data, e.data);
      check({name, "_cycle"}, cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (bus.rf_wr_en) begin
        wr_count++;
        last_wr_addr = int'(bus.rf_addr);
        last_wr_data = int'(bus.rf_wr_data);
        match_ev("rf_wr", K_WR, last_wr_addr, last_wr_data);
      end
      if (bus.rf_rd_en) begin
        rd_count++;
        last_rd_addr = int'(bus.rf_addr);
        match_ev("rf_rd", K_RD, last_rd_addr, 0);
      end
      if (bus.alu_en) begin
        alu_count++;
        last_func = int'(bus.alu_func);
        match_ev("alu_en", K_ALU, 0, last_func);
      end
      if (hold_pending) begin
        check("tx_valid_held", int'(bus.tx_valid_out), 1);
        check("tx_data_stable", int'(bus.tx_data_out), held_data);
      end
      if (bus.tx_valid_out && bus.tx_ready_in) begin
        tx_count++;
        tx_hist.push_back(int'(bus.tx_data_out));
        if (tx_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_unexpected: got byte 0x%0h, required none", bus.tx_data_out);
        end else begin
          check("tx_byte", int'(bus.tx_data_out), tx_q.pop_front());
          if (tx_q.size() == 0 && wait_kind == 3) wait_kind = 0;
        end
      end
      hold_pending = bus.tx_valid_out && !bus.tx_ready_in;
      held_data    = int'(bus.tx_data_out);
      if (bus.frame_err_out) begin
        err_pulses++;
        err_cyc = cyc;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_valid_in = 1'b0; bus.rx_data_in = '0;
    bus.rf_rd_data = '0;    bus.rf_rd_valid = 1'b0;
    bus.alu_out = '0;       bus.alu_out_valid = 1'b0;
    bus.tx_ready_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", out_vec(), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: RF write
    base = wr_count;
    send_byte('hAA); send_byte('h05); send_byte('h3C);
    repeat (3) @(posedge clk);
    check("t1_wr_count", wr_count - base, 1);
    check("t1_wr_addr", last_wr_addr, 5);
    check("t1_wr_data", last_wr_data, 'h3C);

    // 2: RF read with TX back-pressure
    bus.tx_ready_in = 1'b0;
    base = tx_count;
    send_byte('hBB); send_byte('h05);
    respond_rd('h3C, 1'b0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t2_valid_while_stalled", int'(bus.tx_valid_out), 1);
    check("t2_data_while_stalled", int'(bus.tx_data_out), 'h3C);
    @(posedge clk); #1;
    bus.tx_ready_in = 1'b1;
    wait_tx_done(20);
    repeat (3) @(posedge clk);
    check("t2_tx_count", tx_count - base, 1);
    check("t2_rd_addr", last_rd_addr, 5);
    check("t2_tx_byte", tx_hist[$], 'h3C);

    // 2b: byte coinciding with rf_rd_valid is dropped, next frame is clean
    send_byte('hBB); send_byte('h13);
    respond_rd('h99, 1'b1, 'hAA);
    wait_tx_done(20);
    send_byte('hAA); send_byte('h07); send_byte('h11);
    repeat (3) @(posedge clk);
    check("t2b_rd_addr_low_nibble", last_rd_addr, 3);
    check("t2b_wr_addr", last_wr_addr, 7);
    check("t2b_wr_data", last_wr_data, 'h11);

    // 3: ALU with operands
    base = wr_count;
    send_byte('hCC); send_byte('h12); send_byte('h34); send_byte('h01);
    repeat (2) @(posedge clk);
    respond_alu('hABCD);
    wait_tx_done(20);
    check("t3_wr_count", wr_count - base, 2);
    check("t3_func", last_func, 1);
    check("t3_tx_lsb", tx_hist[tx_hist.size()-2], 'hCD);
    check("t3_tx_msb", tx_hist[tx_hist.size()-1], 'hAB);

    // 4: junk in IDLE and during ALU_WAIT
    base = alu_count;
    send_byte('h77); send_byte('hDD); send_byte('h02);
    send_byte('h55);
    respond_alu('h5A0F);
    wait_tx_done(20);
    check("t4_alu_count", alu_count - base, 1);
    check("t4_func", last_func, 2);
    check("t4_tx_lsb", tx_hist[tx_hist.size()-2], 'h0F);
    base = tx_count;
    respond_rd('h44, 1'b0, 0);
    respond_alu('h1234);
    repeat (4) @(posedge clk);
    check("t4_stray_responses_ignored", tx_count - base, 0);

    // 5: reset mid-frame
    base = wr_count;
    send_byte('hAA); send_byte('h01);
    reset_dut();
    repeat (2) @(posedge clk);
    check("t5_no_wr_after_reset", wr_count - base, 0);
    send_byte('hAA); send_byte('h01); send_byte('hFF);
    repeat (3) @(posedge clk);
    check("t5_wr_count", wr_count - base, 1);
    check("t5_wr_addr", last_wr_addr, 1);
    check("t5_wr_data", last_wr_data, 'hFF);

    // 6: partial frame followed by silence
    base = wr_count;
    send_byte('hAA);
    aa_cyc = byte_cyc;
    repeat (30) @(posedge clk);
`ifdef SYS_CTRL_TIMEOUT_EN
    frame.delete();
    check("t6_err_pulses", err_pulses, 1);
    check("t6_err_latency_ok", int'((err_cyc - aa_cyc) >= 16 && (err_cyc - aa_cyc) <= 18), 1);
`endif
    send_byte('h05); send_byte('hFF);
    repeat (4) @(posedge clk);
`ifdef SYS_CTRL_TIMEOUT_EN
    check("t6_no_wr", wr_count - base, 0);
    check("t6_err_pulses_final", err_pulses, 1);
`else
    check("t6_wr_after_wait", wr_count - base, 1);
    check("t6_wr_addr", last_wr_addr, 5);
    check("t6_err_tied_low", err_pulses, 0);
`endif

    check("end_events_drained", exp_q.size(), 0);
    check("end_tx_drained", tx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
